// File: rtl/multicycle_control.sv
// Multi-cycle main control unit for the LEGv8 datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives alu_op and all datapath enables, and handshakes memory via req/ready.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg2loc,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExecR  = 4'd3,
        StExecI  = 4'd4,
        StAddr   = 4'd5,
        StMemRd  = 4'd6,
        StMemWr  = 4'd7,
        StWbAlu  = 4'd8,
        StWbMem  = 4'd9,
        StBranch = 4'd10
    } state_e;

    // Instruction class, latched when leaving DECODE so later opcode changes are ignored.
    typedef enum logic [2:0] {
        ClsR   = 3'd0,
        ClsI   = 3'd1,
        ClsLd  = 3'd2,
        ClsSt  = 3'd3,
        ClsCbz = 3'd4,
        ClsB   = 3'd5,
        ClsBad = 3'd6
    } cls_e;

    state_e      r_state;
    cls_e        r_cls;
    logic        r_run;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_pc_src;
    logic        r_alu_src;
    logic [1:0]  r_alu_op;
    logic        r_reg2loc;
    logic        r_reg_write;
    logic        r_mem_to_reg;

    state_e      w_state_nxt;
    cls_e        w_cls_nxt;
    cls_e        w_dec_cls;

    // Opcode classification; only consumed while in DECODE.
    always_comb begin
        w_dec_cls = ClsBad;
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: w_dec_cls = ClsR;
            11'b1001000100?: w_dec_cls = ClsI;
            11'b11111000010: w_dec_cls = ClsLd;
            11'b11111000000: w_dec_cls = ClsSt;
            11'b10110100???: w_dec_cls = ClsCbz;
            11'b000101?????: w_dec_cls = ClsB;
            default:         w_dec_cls = ClsBad;
        endcase
    end

    // Next-state and next-class selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cls_nxt   = r_cls;
        case (r_state)
            // First edge after reset release only arms r_run; the second enters FETCH.
            StIdle:   if (r_run) w_state_nxt = StFetch;
            StFetch:  if (mem_ready) w_state_nxt = StDecode;
            StDecode: begin
                w_cls_nxt = w_dec_cls;
                case (w_dec_cls)
                    ClsR:          w_state_nxt = StExecR;
                    ClsI:          w_state_nxt = StExecI;
                    ClsLd, ClsSt:  w_state_nxt = StAddr;
                    ClsCbz, ClsB:  w_state_nxt = StBranch;
                    default:       w_state_nxt = StFetch;
                endcase
            end
            StExecR,
            StExecI:  w_state_nxt = StWbAlu;
            StAddr:   w_state_nxt = (r_cls == ClsSt) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) w_state_nxt = StWbMem;
            StMemWr:  if (mem_ready) w_state_nxt = StFetch;
            StWbAlu,
            StWbMem,
            StBranch: w_state_nxt = StFetch;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // State, latched class and Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cls        <= ClsBad;
            r_run        <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_pc_src     <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 2'b00;
            r_reg2loc    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_state      <= w_state_nxt;
            r_cls        <= w_cls_nxt;
            r_mem_req    <= (w_state_nxt inside {StFetch, StMemRd, StMemWr});
            r_mem_we     <= (w_state_nxt == StMemWr);
            r_pc_src     <= (w_state_nxt == StBranch);
            r_alu_src    <= (w_state_nxt inside {StExecI, StAddr});
            r_reg2loc    <= (w_state_nxt == StMemWr) ||
                            ((w_state_nxt == StAddr) && (w_cls_nxt == ClsSt)) ||
                            ((w_state_nxt == StBranch) && (w_cls_nxt == ClsCbz));
            r_reg_write  <= (w_state_nxt inside {StWbAlu, StWbMem});
            r_mem_to_reg <= (w_state_nxt == StWbMem);
            // alu_op follows the class for the whole instruction body, 00 through fetch/decode.
            if (w_state_nxt inside {StIdle, StFetch, StDecode}) begin
                r_alu_op <= 2'b00;
            end else if (w_cls_nxt == ClsR) begin
                r_alu_op <= 2'b10;
            end else if (w_cls_nxt == ClsCbz) begin
                r_alu_op <= 2'b01;
            end else begin
                r_alu_op <= 2'b00;
            end
        end
    end

    // Input-qualified strobes: fetch completion, taken branch, undecodable opcode.
    assign ir_write   = (r_state == StFetch) && mem_ready;
    assign pc_write   = ir_write ||
                        ((r_state == StBranch) && ((r_cls == ClsB) || zero));
    assign illegal    = (r_state == StDecode) && (w_dec_cls == ClsBad);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign pc_src     = r_pc_src;
    assign alu_src    = r_alu_src;
    assign alu_op     = r_alu_op;
    assign reg2loc    = r_reg2loc;
    assign reg_write  = r_reg_write;
    assign mem_to_reg = r_mem_to_reg;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a reference model expands each
// instruction into its expected per-cycle output trace, a monitor compares.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        reg2loc, reg_write, mem_to_reg, illegal;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg2loc    (reg2loc),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
    );

    typedef enum int {CR, CI, CLD, CST, CCBZ, CB, CBAD} cls_e;

    // One expected cycle: output vector plus how the inputs must be driven.
    typedef struct packed {
        logic [11:0] v;
        logic        care;  // mem_ready is meaningful this cycle
        logic        rdy;
        logic        dec;   // DECODE cycle: drive the real opcode
        logic        br;    // BRANCH cycle: drive the real zero flag
    } cyc_t;

    cyc_t        trace[$];
    logic [11:0] sb[$];
    logic [11:0] exp_v;
    logic [10:0] cur_opc;
    logic        cur_z;
    logic        mon_en = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    wire [11:0] act = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
                       reg2loc, reg_write, mem_to_reg, illegal};

    function automatic logic [11:0] ev(input logic req, input logic we, input logic irw,
                                       input logic pcw, input logic pcs, input logic asrc,
                                       input logic [1:0] aop, input logic r2l, input logic rw,
                                       input logic m2r, input logic ill);
        return {req, we, irw, pcw, pcs, asrc, aop, r2l, rw, m2r, ill};
    endfunction

    function automatic cls_e classify(input logic [10:0] o);
        if (o == 11'b10001011000 || o == 11'b11001011000 ||
            o == 11'b10001010000 || o == 11'b10101010000) return CR;
        if (o[10:1] == 10'b1001000100) return CI;
        if (o == 11'b11111000010) return CLD;
        if (o == 11'b11111000000) return CST;
        if (o[10:3] == 8'b10110100) return CCBZ;
        if (o[10:5] == 6'b000101) return CB;
        return CBAD;
    endfunction

    function automatic void put(input logic [11:0] v, input logic care, input logic rdy,
                                input logic dec, input logic br);
        trace.push_back('{v, care, rdy, dec, br});
    endfunction

    // Reference model: expected cycle trace of one instruction.
    task automatic build(input logic [10:0] opc, input int fw, input int dw, input logic z);
        cls_e c;
        c = classify(opc);
        cur_opc = opc;
        cur_z = z;
        trace.delete();
        for (int i = 0; i < fw; i++) put(ev(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 1, 0, 0, 0);
        put(ev(1, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0), 1, 1, 0, 0);
        put(ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, c == CBAD), 0, 0, 1, 0);
        case (c)
            CR: begin
                put(ev(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0), 0, 0, 0, 0);
                put(ev(0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0), 0, 0, 0, 0);
            end
            CI: begin
                put(ev(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 0, 0, 0, 0);
                put(ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), 0, 0, 0, 0);
            end
            CLD: begin
                put(ev(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 0, 0, 0, 0);
                for (int i = 0; i < dw; i++)
                    put(ev(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 1, 0, 0, 0);
                put(ev(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 1, 1, 0, 0);
                put(ev(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0), 0, 0, 0, 0);
            end
            CST: begin
                put(ev(0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0), 0, 0, 0, 0);
                for (int i = 0; i < dw; i++)
                    put(ev(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0), 1, 0, 0, 0);
                put(ev(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0), 1, 1, 0, 0);
            end
            CCBZ: put(ev(0, 0, 0, z, 1, 0, 2'b01, 1, 0, 0, 0), 0, 0, 0, 1);
            CB:   put(ev(0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0), 0, 0, 0, 1);
            default: ;
        endcase
    endtask

    // Drive the first n cycles of the trace, noise on don't-care inputs.
    task automatic run_trace(input int n);
        for (int i = 0; i < n && i < trace.size(); i++) begin
            @(posedge clk);
            #1;
            mem_ready = trace[i].care ? trace[i].rdy : 1'($urandom_range(0, 1));
            opcode    = trace[i].dec ? cur_opc : 11'($urandom);
            zero      = trace[i].br ? cur_z : 1'($urandom_range(0, 1));
            sb.push_back(trace[i].v);
        end
    endtask

    task automatic issue(input logic [10:0] opc, input int fw, input int dw, input logic z);
        build(opc, fw, dw, z);
        run_trace(trace.size());
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Release reset just after an edge: two IDLE cycles precede the first FETCH.
    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        sb.push_back(12'h000);
        @(posedge clk);
        #1;
        mem_ready = 1'($urandom_range(0, 1));
        sb.push_back(12'h000);
    endtask

    // Monitor: every cycle the DUT presents one output vector to compare.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got %b want <none> at %0t", act, $time);
            end else begin
                exp_v = sb.pop_front();
                if (act !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_outputs: got %b want %b (req we irw pcw pcs asrc aop r2l rw m2r ill) at %0t",
                             act, exp_v, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    logic [10:0] r_ops [4];
    logic [10:0] opc;

    initial begin
        r_ops[0] = 11'b10001011000;
        r_ops[1] = 11'b11001011000;
        r_ops[2] = 11'b10001010000;
        r_ops[3] = 11'b10101010000;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(act), 0);
        chk("reset_state", 32'(state), 0);
        release_rst();

        // Directed cases
        issue(11'b10001011000, 0, 0, 1'b0);  // ADD
        issue(11'b11111000010, 2, 3, 1'b0);  // LDUR, 10 cycles
        issue(11'b11111000000, 0, 1, 1'b0);  // STUR
        issue(11'b10110100101, 0, 0, 1'b1);  // CBZ taken
        issue(11'b10110100101, 1, 0, 1'b0);  // CBZ not taken
        issue(11'b00010100000, 0, 0, 1'b0);  // B ignores zero
        issue(11'b00000000000, 0, 0, 1'b0);  // illegal

        // Reset mid-MEM_RD abandons the access immediately
        build(11'b11111000010, 0, 6, 1'b0);
        run_trace(5);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        chk("pre_reset_mem_req", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(act), 0);
        chk("async_reset_state", 32'(state), 0);
        chk("async_reset_sb_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_outputs", 32'(act), 0);
        release_rst();

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: opc = r_ops[$urandom_range(0, 3)];
                4: opc = {10'b1001000100, 1'($urandom_range(0, 1))};
                5: opc = 11'b11111000010;
                6: opc = 11'b11111000000;
                7: opc = {8'b10110100, 3'($urandom)};
                8: opc = {6'b000101, 5'($urandom)};
                default: begin
                    opc = 11'b00000000000;
                    for (int t = 0; t < 100; t++) begin
                        opc = 11'($urandom);
                        if (classify(opc) == CBAD) break;
                    end
                    if (classify(opc) != CBAD) opc = 11'b00000000000;
                end
            endcase
            issue(opc, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the LEGv8 datapath. It sits directly upstream of the ALU control stage: it decodes the instruction opcode field (inst[31:21]), sequences each instruction through fetch/decode/execute/memory/writeback states, and drives `alu_op[1:0]` together with all other datapath enables. Memory accesses use a req/ready handshake, so fetch and data accesses may take any number of cycles.

## Interface
- No parameters. State encoding is internal; `state` exposes it for debug only.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 11: inst[31:21] from the instruction register. Valid from DECODE onward.
- `zero` in 1: ALU zero flag. Sampled in BRANCH only.
- `mem_ready` in 1: memory access complete. Ignored while `mem_req`=0.
- `mem_req` out 1: memory access request, held until `mem_ready`.
- `mem_we` out 1: 1 = write access (STUR data phase only).
- `ir_write` out 1: load IR from memory read data.
- `pc_write` out 1: load PC.
- `pc_src` out 1: 0 = PC+4, 1 = branch target.
- `alu_src` out 1: 0 = register operand B, 1 = sign-extended immediate.
- `alu_op` out 2: 00 = add, 01 = CBZ pass-B, 10 = R-type decode by opcode.
- `reg2loc` out 1: 1 = read-register-2 taken from Rt (STUR, CBZ).
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: 1 = writeback data from memory.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.
- `state` out 4: current state, debug only.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH.
- Outputs are Moore-decoded from `state`, except `ir_write`/`pc_write` in FETCH and `pc_write` in BRANCH, which are qualified by inputs.
- Any output not listed for a state is 0.
- IDLE: no outputs asserted. Unconditional transition to FETCH.
- FETCH:
  - `mem_req`=1 and `alu_op`=00.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify `opcode` (x = don't care):
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) -> EXEC_R.
  - ADDI 1001000100x -> EXEC_I.
  - LDUR 11111000010, STUR 11111000000 -> ADDR.
  - CBZ 10110100xxx, B 000101xxxxx -> BRANCH.
  - Anything else -> `illegal`=1 for that cycle, then FETCH.
- EXEC_R: `alu_op`=10, `alu_src`=0, then WB_ALU.
- EXEC_I: `alu_op`=00, `alu_src`=1, then WB_ALU.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0, then FETCH.
- ADDR: `alu_op`=00, `alu_src`=1. `reg2loc`=1 if STUR. Then MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: `mem_req`=1, `mem_we`=0. On `mem_ready` go to WB_MEM, else stay.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `reg2loc`=1. On `mem_ready` go to FETCH, else stay.
- BRANCH: `pc_src`=1.
  - CBZ: `alu_op`=01, `reg2loc`=1, `pc_write`=`zero`.
  - B: `pc_write`=1.
  - Next state is always FETCH.
- `alu_op` holds its DECODE-determined value through the last state of the instruction. It returns to 00 only on entry to FETCH.

## Timing
- Reset:
  - `rst_n`=0 forces state to IDLE immediately, asynchronously. All outputs go to 0, including `state`=IDLE.
  - An in-flight access is abandoned: `mem_req` drops with no wait for `mem_ready`.
  - The first FETCH occurs on the second rising edge after `rst_n` deasserts.
- Minimum cycles per instruction, with `mem_ready` high on the first request cycle:
  - R-type and ADDI: 4.
  - LDUR: 5.
  - STUR: 4.
  - CBZ and B: 3.
  - Illegal opcode: 2.
- Each wait cycle on `mem_ready` adds exactly one cycle. `mem_ready` asserted in the same cycle as `mem_req` completes that access.
- `mem_req` stays high continuously across wait cycles. `mem_we` and `mem_req` never change while waiting.
- `ir_write` and `pc_write` are asserted in the same cycle and only once per fetch.
- `mem_ready` high in a non-memory state has no effect.
- `opcode` changes outside DECODE have no effect: the class is latched at the DECODE exit.

## Test plan
- Reset: hold `rst_n`=0 mid-MEM_RD with `mem_req`=1 -> all outputs 0 immediately. After release: IDLE, then FETCH with `mem_req`=1 one cycle later.
- ADD (10001011000), `mem_ready`=1 always -> states FETCH, DECODE, EXEC_R, WB_ALU. `alu_op`=10 in EXEC_R and WB_ALU; `reg_write`=1 only in WB_ALU; 4 cycles total.
- LDUR with fetch wait 2 and data wait 3 -> `mem_req` high 3 cycles in FETCH and 4 cycles in MEM_RD; `ir_write` pulses once; `mem_to_reg`=`reg_write`=1 in WB_MEM; 10 cycles total.
- STUR (11111000000) -> `reg2loc`=1 in ADDR and MEM_WR; `mem_we`=1 only in MEM_WR; `reg_write` never asserted.
- CBZ (10110100xxx) with `zero`=1 then `zero`=0 -> `pc_write`=1 and `pc_src`=1 in BRANCH for the first, `pc_write`=0 for the second; `alu_op`=01. B (00010100000) -> `pc_write`=1 regardless of `zero`.
- Opcode 00000000000 -> `illegal`=1 for exactly one cycle in DECODE, then FETCH; no `reg_write`, `mem_req` or `pc_write` during the instruction.
